hazard_flush_controller: RTL and testbench
==========================================

Name: hazard_flush_controller

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Consumes the EX-stage branch decision (Switch_Branch), load-use hazard operands and the data-memory busy flag.
- Produces PC-write, IF/ID-write, per-stage flush/hold and PC-redirect controls.
- Holds an FSM for multi-cycle squash and memory wait, buffers branches that resolve during a memory stall, and keeps saturating flush/stall performance counters.

Parameters:
- PC_W, 64, PC / branch-target width.
- REG_ADDR_W, 5, register-index width.
- FLUSH_CYCLES, 2, total cycles IF/ID is squashed per taken branch (≥1).
- CNT_W, 16, performance counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- branch_taken  input  1  EX-stage taken-branch decision.
- branch_target  input  PC_W  EX-stage target address.
- id_ex_mem_read  input  1  instruction in EX is a load.
- id_ex_rd  input  REG_ADDR_W  load destination register.
- if_id_rs1  input  REG_ADDR_W  ID source 1.
- if_id_rs2  input  REG_ADDR_W  ID source 2.
- if_id_uses_rs2  input  1  ID instruction reads rs2.
- mem_busy  input  1  data memory not ready; pipeline must freeze.
- pc_write  output  1  PC register enable.
- if_id_write  output  1  IF/ID register enable.
- if_id_flush  output  1  zero IF/ID.
- id_ex_flush  output  1  insert bubble into ID/EX.
- ex_mem_hold  output  1  freeze EX/MEM and MEM/WB.
- pc_sel  output  1  1 = next PC is redirect_pc.
- redirect_pc  output  PC_W  redirect address.
- state_o  output  2  current FSM state.
- flush_count  output  CNT_W  taken-branch redirect events, saturating.
- stall_count  output  CNT_W  stall cycles (load-use + mem wait), saturating.

Behaviour:
- Reset (async assert, sync deassert):
  - state=RUN, pending_valid=0, pending_target=0, squash counter=0, both perf counters=0.
  - Outputs: pc_write=1, if_id_write=1, all flushes/holds=0, pc_sel=0, redirect_pc=0.
- State encoding: RUN=0, REDIRECT=1, LU_STALL=2, MEM_WAIT=3. Outputs are combinational from state plus inputs; state and counters are registered.
- Priority in RUN: mem_busy > branch_taken > load-use.
- Default outputs: pc_write=1, if_id_write=1, all others 0.
- RUN, mem_busy=1:
  - pc_write=0, if_id_write=0, ex_mem_hold=1, no flushes.
  - If branch_taken=1, capture pending_valid=1 and pending_target=branch_target.
  - Next state MEM_WAIT; stall_count+1.
- RUN, branch_taken=1 (redirect event, 0-cycle latency):
  - pc_sel=1, redirect_pc=branch_target, if_id_flush=1, id_ex_flush=1; flush_count+1.
  - If FLUSH_CYCLES>1: next REDIRECT with squash counter=FLUSH_CYCLES-1. Otherwise next RUN.
- RUN, load-use hit:
  - Hit condition: id_ex_mem_read & id_ex_rd≠0 & (id_ex_rd==if_id_rs1 | (if_id_uses_rs2 & id_ex_rd==if_id_rs2)).
  - pc_write=0, if_id_write=0, id_ex_flush=1; stall_count+1; next LU_STALL.
- LU_STALL:
  - Exactly one cycle with default outputs; hazard detection is suppressed.
  - mem_busy=1 goes to MEM_WAIT with the RUN mem_busy outputs. Otherwise next RUN.
- REDIRECT:
  - if_id_flush=1 and counter decrements; branch_taken is ignored because EX holds a bubble.
  - Counter reaching 1 → next RUN.
  - mem_busy=1 freezes the counter and asserts ex_mem_hold, pc_write=0, if_id_write=0.
- MEM_WAIT, mem_busy=1:
  - Freeze outputs as in RUN, stall_count+1.
  - A branch_taken while pending_valid=0 captures target. Further branch_taken is ignored (same frozen EX instruction).
- MEM_WAIT, mem_busy=0:
  - If pending_valid: perform the redirect event with pending_target. Clear pending and transition as RUN. A concurrent branch_taken is the same event, counted once.
  - Else: evaluate exactly as RUN this cycle.
- Counters saturate at all-ones and never wrap.
- Reset mid-REDIRECT or mid-MEM_WAIT discards the counter and pending branch.

Decomposition:
- Package hazard_pkg holds:
  - the state enum (RUN/REDIRECT/LU_STALL/MEM_WAIT);
  - default widths PC_W, REG_ADDR_W, CNT_W;
  - the default FLUSH_CYCLES constant.
- Sub-module sat_counter (parameter CNT_W; inputs clk, reset, inc; output count) is instantiated twice, for flush_count and stall_count.

Test Plan:
- Reset, then branch_taken=1, target=0x0000_0000_0000_0100 in RUN → same cycle pc_sel=1, redirect_pc=0x100, both flushes=1. Next cycle state=REDIRECT, if_id_flush=1. Then RUN. flush_count=1.
- Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rs1=5 → one cycle pc_write=0, if_id_write=0, id_ex_flush=1. Next cycle state=LU_STALL with no stall. stall_count=1. With id_ex_rd=0 → no stall.
- mem_busy high 3 cycles with branch_taken=1, target=0x200 in the first → 3 cycles ex_mem_hold=1, pc_write=0. On the release cycle pc_sel=1, redirect_pc=0x200. flush_count+1 only; stall_count+3.
- Simultaneous branch_taken and load-use hit in RUN → redirect wins, id_ex_flush=1, pc_write=1, stall_count unchanged.
- Drive 70000 redirect events → flush_count holds 0xFFFF.
- Assert reset during REDIRECT and during MEM_WAIT with a pending branch → all outputs immediately at reset values, state_o=0. After release, no stale redirect.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and default sizing for the pipeline hazard/flush controller.
//   state_e        - controller FSM state, encoding visible on state_o
//   DefPcW         - default PC / branch-target width
//   DefRegAddrW    - default register-index width
//   DefCntW        - default performance-counter width
//   DefFlushCycles - default IF/ID squash length per taken branch
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StRedirect = 2'd1,
    StLuStall  = 2'd2,
    StMemWait  = 2'd3
  } state_e;

  localparam int unsigned DefPcW         = 64;
  localparam int unsigned DefRegAddrW    = 5;
  localparam int unsigned DefCntW        = 16;
  localparam int unsigned DefFlushCycles = 2;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset, clears the count
//   inc   - count one event this cycle
//   count - current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_flush_controller.sv
// hazard_flush_controller: pipeline sequencing for the 5-stage core.
// Inputs : clk, reset (async active-low), branch_taken/branch_target (EX decision),
//          id_ex_mem_read/id_ex_rd and if_id_rs1/if_id_rs2/if_id_uses_rs2 (load-use
//          operands), mem_busy (data memory not ready).
// Outputs: pc_write, if_id_write (enables), if_id_flush, id_ex_flush, ex_mem_hold,
//          pc_sel/redirect_pc (PC redirect), state_o (FSM state),
//          flush_count/stall_count (saturating performance counters).
// Outputs are combinational from the registered state plus the current inputs.
module hazard_flush_controller
  import hazard_pkg::*;
#(
  parameter int unsigned PC_W         = DefPcW,
  parameter int unsigned REG_ADDR_W   = DefRegAddrW,
  parameter int unsigned FLUSH_CYCLES = DefFlushCycles,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_taken,
  input  logic [PC_W-1:0]       branch_target,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_uses_rs2,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_hold,
  output logic                  pc_sel,
  output logic [PC_W-1:0]       redirect_pc,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      stall_count
);

  // Squash counter holds the remaining extra squash cycles (at most FLUSH_CYCLES-1).
  localparam int unsigned SqW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e          r_state;
  logic            r_pend_valid;
  logic [PC_W-1:0] r_pend_target;
  logic [SqW-1:0]  r_squash;

  state_e          w_state_d;
  logic            w_pend_valid_d;
  logic [PC_W-1:0] w_pend_target_d;
  logic [SqW-1:0]  w_squash_d;

  logic            w_lu_hit;
  logic            w_run_eval;   // apply the RUN priority chain this cycle
  logic            w_lu_en;      // load-use detection allowed in that evaluation
  logic            w_redir;      // a redirect event fires this cycle
  logic [PC_W-1:0] w_redir_tgt;
  logic            w_flush_inc;
  logic            w_stall_inc;

  assign w_lu_hit = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

  always_comb begin
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_hold     = 1'b0;
    pc_sel          = 1'b0;
    redirect_pc     = '0;
    w_state_d       = r_state;
    w_pend_valid_d  = r_pend_valid;
    w_pend_target_d = r_pend_target;
    w_squash_d      = r_squash;
    w_run_eval      = 1'b0;
    w_lu_en         = 1'b0;
    w_redir         = 1'b0;
    w_redir_tgt     = branch_target;
    w_flush_inc     = 1'b0;
    w_stall_inc     = 1'b0;

    unique case (r_state)
      StRun: begin
        w_run_eval = 1'b1;
        w_lu_en    = 1'b1;
      end
      StLuStall: begin
        // The bubble cycle: only a memory stall can change what happens here.
        if (mem_busy) begin
          w_run_eval = 1'b1;
        end else begin
          w_state_d = StRun;
        end
      end
      StRedirect: begin
        // EX holds a bubble, so branch_taken is not looked at.
        if_id_flush = 1'b1;
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_mem_hold = 1'b1;
        end else if (r_squash <= SqW'(1)) begin
          w_squash_d = '0;
          w_state_d  = StRun;
        end else begin
          w_squash_d = r_squash - SqW'(1);
        end
      end
      StMemWait: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_mem_hold = 1'b1;
          w_stall_inc = 1'b1;
          // The frozen EX instruction can only resolve one branch.
          if (branch_taken && !r_pend_valid) begin
            w_pend_valid_d  = 1'b1;
            w_pend_target_d = branch_target;
          end
        end else if (r_pend_valid) begin
          // A concurrent branch_taken is the same buffered branch: one event.
          w_redir        = 1'b1;
          w_redir_tgt    = r_pend_target;
          w_pend_valid_d = 1'b0;
        end else begin
          w_run_eval = 1'b1;
          w_lu_en    = 1'b1;
        end
      end
      default: w_state_d = StRun;
    endcase

    if (w_run_eval) begin
      if (mem_busy) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ex_mem_hold = 1'b1;
        w_stall_inc = 1'b1;
        w_state_d   = StMemWait;
        if (branch_taken) begin
          w_pend_valid_d  = 1'b1;
          w_pend_target_d = branch_target;
        end
      end else if (branch_taken) begin
        w_redir = 1'b1;
      end else if (w_lu_en && w_lu_hit) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        w_stall_inc = 1'b1;
        w_state_d   = StLuStall;
      end else begin
        w_state_d = StRun;
      end
    end

    if (w_redir) begin
      pc_sel      = 1'b1;
      redirect_pc = w_redir_tgt;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_flush_inc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_d  = StRedirect;
        w_squash_d = SqW'(FLUSH_CYCLES - 1);
      end else begin
        w_state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StRun;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_squash      <= '0;
    end else begin
      r_state       <= w_state_d;
      r_pend_valid  <= w_pend_valid_d;
      r_pend_target <= w_pend_target_d;
      r_squash      <= w_squash_d;
    end
  end

  assign state_o = r_state;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_flush_inc),
    .count(flush_count)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_stall_inc),
    .count(stall_count)
  );

endmodule

// File: tb/tb_hazard_flush_controller.sv
// tb_hazard_flush_controller: directed + randomized stimulus against a behavioural
// model of the controller (squash window length, bubble flag, memory-wait flag,
// buffered branch and event totals).
module tb_hazard_flush_controller;

  localparam int unsigned TbPcW    = 64;
  localparam int unsigned TbRegW   = 5;
  localparam int unsigned TbFlush  = 2;
  // Narrow counters so saturation is reachable in a short run.
  localparam int unsigned TbCntW   = 10;
  localparam int          CntMax   = (1 << TbCntW) - 1;

  logic              clk;
  logic              reset;
  logic              branch_taken;
  logic [TbPcW-1:0]  branch_target;
  logic              id_ex_mem_read;
  logic [TbRegW-1:0] id_ex_rd;
  logic [TbRegW-1:0] if_id_rs1;
  logic [TbRegW-1:0] if_id_rs2;
  logic              if_id_uses_rs2;
  logic              mem_busy;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_hold;
  logic              pc_sel;
  logic [TbPcW-1:0]  redirect_pc;
  logic [1:0]        state_o;
  logic [TbCntW-1:0] flush_count;
  logic [TbCntW-1:0] stall_count;

  hazard_flush_controller #(
    .PC_W        (TbPcW),
    .REG_ADDR_W  (TbRegW),
    .FLUSH_CYCLES(TbFlush),
    .CNT_W       (TbCntW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .if_id_uses_rs2(if_id_uses_rs2),
    .mem_busy      (mem_busy),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_hold   (ex_mem_hold),
    .pc_sel        (pc_sel),
    .redirect_pc   (redirect_pc),
    .state_o       (state_o),
    .flush_count   (flush_count),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: remaining squash cycles, bubble pending, waiting on memory, buffered branch.
  int               m_squash;
  bit               m_bubble;
  bit               m_memwait;
  bit               m_pv;
  logic [TbPcW-1:0] m_pt;
  int               m_fc;
  int               m_sc;

  task automatic model_reset();
    m_squash  = 0;
    m_bubble  = 0;
    m_memwait = 0;
    m_pv      = 0;
    m_pt      = '0;
    m_fc      = 0;
    m_sc      = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit bt, input logic [TbPcW-1:0] tgt, input bit mr,
                      input logic [TbRegW-1:0] rd, input logic [TbRegW-1:0] rs1,
                      input logic [TbRegW-1:0] rs2, input bit u2, input bit busy);
    bit               e_pcw, e_ifw, e_iff, e_idf, e_hold, e_sel;
    logic [TbPcW-1:0] e_rpc;
    int               e_state;
    bit               hit, redir;
    logic [TbPcW-1:0] rtgt;
    int               n_squash;
    bit               n_bubble, n_memwait, n_pv;
    logic [TbPcW-1:0] n_pt;
    int               n_fc, n_sc;

    branch_taken   = bt;
    branch_target  = tgt;
    id_ex_mem_read = mr;
    id_ex_rd       = rd;
    if_id_rs1      = rs1;
    if_id_rs2      = rs2;
    if_id_uses_rs2 = u2;
    mem_busy       = busy;

    hit = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
    e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0; e_sel = 0; e_rpc = '0;
    e_state = m_memwait ? 3 : (m_squash > 0) ? 1 : m_bubble ? 2 : 0;
    n_squash = m_squash; n_bubble = 0; n_memwait = m_memwait; n_pv = m_pv; n_pt = m_pt;
    n_fc = m_fc; n_sc = m_sc;
    redir = 0; rtgt = tgt;

    if (m_squash > 0) begin
      e_iff = 1;
      if (busy) begin
        e_pcw = 0; e_ifw = 0; e_hold = 1;
      end else begin
        n_squash = m_squash - 1;
      end
    end else if (m_memwait && busy) begin
      e_pcw = 0; e_ifw = 0; e_hold = 1;
      n_sc = m_sc + 1;
      if (bt && !m_pv) begin
        n_pv = 1; n_pt = tgt;
      end
    end else if (m_memwait && m_pv) begin
      redir = 1; rtgt = m_pt; n_pv = 0; n_memwait = 0;
    end else begin
      n_memwait = 0;
      if (busy) begin
        e_pcw = 0; e_ifw = 0; e_hold = 1;
        n_sc = m_sc + 1; n_memwait = 1;
        if (bt) begin
          n_pv = 1; n_pt = tgt;
        end
      end else if (!m_bubble && bt) begin
        redir = 1;
      end else if (!m_bubble && hit) begin
        e_pcw = 0; e_ifw = 0; e_idf = 1;
        n_sc = m_sc + 1; n_bubble = 1;
      end
    end

    if (redir) begin
      e_sel = 1; e_rpc = rtgt; e_iff = 1; e_idf = 1;
      n_fc = m_fc + 1;
      n_squash = TbFlush - 1;
    end
    if (n_fc > CntMax) n_fc = CntMax;
    if (n_sc > CntMax) n_sc = CntMax;

    @(negedge clk);
    chk("state_o", 64'(state_o), 64'(e_state));
    chk("pc_write", 64'(pc_write), 64'(e_pcw));
    chk("if_id_write", 64'(if_id_write), 64'(e_ifw));
    chk("if_id_flush", 64'(if_id_flush), 64'(e_iff));
    chk("id_ex_flush", 64'(id_ex_flush), 64'(e_idf));
    chk("ex_mem_hold", 64'(ex_mem_hold), 64'(e_hold));
    chk("pc_sel", 64'(pc_sel), 64'(e_sel));
    chk("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
    chk("flush_count", 64'(flush_count), 64'(m_fc));
    chk("stall_count", 64'(stall_count), 64'(m_sc));

    @(posedge clk);
    #1;
    m_squash = n_squash; m_bubble = n_bubble; m_memwait = n_memwait;
    m_pv = n_pv; m_pt = n_pt; m_fc = n_fc; m_sc = n_sc;
  endtask

  task automatic idle();
    step(0, '0, 0, '0, '0, '0, 0, 0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear immediately.
  task automatic mid_reset();
    branch_taken = 0; mem_busy = 0; id_ex_mem_read = 0;
    reset = 1'b0;
    #2;
    chk("rst_state_o", 64'(state_o), 64'd0);
    chk("rst_pc_write", 64'(pc_write), 64'd1);
    chk("rst_if_id_flush", 64'(if_id_flush), 64'd0);
    chk("rst_pc_sel", 64'(pc_sel), 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst_flush_count", 64'(flush_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    branch_taken = 0; branch_target = '0; id_ex_mem_read = 0; id_ex_rd = '0;
    if_id_rs1 = '0; if_id_rs2 = '0; if_id_uses_rs2 = 0; mem_busy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    idle();
    // Taken branch in RUN, squash window, back to RUN.
    step(1, 64'h100, 0, '0, '0, '0, 0, 0);
    idle();
    idle();
    // Load-use on rs1, bubble cycle, then rd=0 never stalls.
    step(0, '0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    step(0, '0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    step(0, '0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
    // Load-use through rs2 only when it is used.
    step(0, '0, 1, 5'd7, 5'd1, 5'd7, 0, 0);
    step(0, '0, 1, 5'd7, 5'd1, 5'd7, 1, 0);
    idle();
    // Memory stall with branch buffered in the first cycle, redirect on release.
    step(1, 64'h200, 0, '0, '0, '0, 0, 1);
    step(1, 64'h300, 0, '0, '0, '0, 0, 1);
    step(0, '0, 0, '0, '0, '0, 0, 1);
    step(1, 64'h200, 0, '0, '0, '0, 0, 0);
    idle();
    idle();
    // Branch and load-use together: redirect wins.
    step(1, 64'h400, 1, 5'd3, 5'd3, 5'd0, 0, 0);
    idle();
    // Memory stall during the squash window freezes it.
    step(1, 64'h500, 0, '0, '0, '0, 0, 0);
    step(0, '0, 0, '0, '0, '0, 0, 1);
    idle();
    idle();

    // Reset during REDIRECT.
    step(1, 64'h600, 0, '0, '0, '0, 0, 0);
    mid_reset();
    idle();
    // Reset during MEM_WAIT with a buffered branch: nothing stale afterwards.
    step(1, 64'h700, 0, '0, '0, '0, 0, 1);
    step(0, '0, 0, '0, '0, '0, 0, 1);
    mid_reset();
    idle();
    idle();

    // Randomized traffic; small register range makes load-use hits frequent.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3) == 0), {$urandom, $urandom}, $urandom_range(1),
           TbRegW'($urandom_range(3)), TbRegW'($urandom_range(3)),
           TbRegW'($urandom_range(3)), $urandom_range(1), ($urandom_range(3) == 0));
    end

    // Drive both counters into saturation.
    for (int i = 0; i < CntMax + 80; i++) begin
      step(1, {$urandom, $urandom}, 0, '0, '0, '0, 0, 0);
      idle();
    end
    for (int i = 0; i < CntMax + 80; i++) begin
      step(0, '0, 0, '0, '0, '0, 0, 1);
    end
    idle();
    idle();
    chk("flush_sat", 64'(flush_count), 64'(CntMax));
    chk("stall_sat", 64'(stall_count), 64'(CntMax));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
